// File: rtl/cp0_exc_ctrl.sv
// Exception/interrupt sequencer in front of CP0: synchronises interrupt lines, prioritises
// traps, pulses CP0's exception/eret inputs, stalls the pipe and redirects the PC.
module cp0_exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0040_0004,
  parameter int          N_INT        = 6,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid_i,
  input  logic [31:0]      pc_i,
  input  logic             syscall_i,
  input  logic             brk_i,
  input  logic             teq_trap_i,
  input  logic             eret_req_i,
  input  logic [N_INT-1:0] ext_int_i,
  input  logic [31:0]      status_i,
  input  logic [31:0]      exc_addr_i,
  output logic             exception_o,
  output logic [4:0]       cause_o,
  output logic [31:0]      epc_pc_o,
  output logic             eret_o,
  output logic             stall_o,
  output logic             redirect_o,
  output logic [31:0]      redirect_pc_o,
  output logic [N_INT-1:0] int_pending_o
);

  typedef enum logic [1:0] {S_IDLE, S_TAKE, S_VECTOR, S_RET} state_e;

  localparam logic [4:0]       EXC_INT = 5'd0;
  localparam logic [4:0]       EXC_SYS = 5'd8;
  localparam logic [4:0]       EXC_BP  = 5'd9;
  localparam logic [4:0]       EXC_TR  = 5'd13;
  localparam logic [N_INT-1:0] ONE     = {{(N_INT-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [4:0]       cause_q, cause_d;
  logic [31:0]      epc_q, epc_d;
  logic [N_INT-1:0] int_take_q, int_take_d;
  logic [N_INT-1:0] pend_q, pend_d;
  logic             in_handler_q, in_handler_d;
  logic [N_INT-1:0] sync_q [SYNC_STAGES];
  logic [N_INT-1:0] int_prev_q;
  logic             stall_c;

  // Bits of Status this block does not interpret.
  logic unused_status;
  assign unused_status = ^{status_i[31:8+N_INT], status_i[7:4]};

  // NOTE: the synchroniser chain is a handful of flops, not a RAM, so it is reset with
  // everything else; a reset-less array here would let X edges set pending bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      int_prev_q <= '0;
    end else begin
      sync_q[0] <= ext_int_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      int_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  logic             gie;
  logic             teq_en, brk_en, sys_en, eret_en;
  logic [N_INT-1:0] int_edge, int_elig, int_sel;

  assign gie      = status_i[0];
  assign teq_en   = instr_valid_i & teq_trap_i & gie & status_i[3];
  assign brk_en   = instr_valid_i & brk_i      & gie & status_i[2];
  assign sys_en   = instr_valid_i & syscall_i  & gie & status_i[1];
  assign eret_en  = instr_valid_i & eret_req_i;
  assign int_edge = sync_q[SYNC_STAGES-1] & ~int_prev_q;
  assign int_elig = pend_q & status_i[8 +: N_INT] & {N_INT{gie & instr_valid_i & ~in_handler_q}};
  // Two's-complement trick isolates the lowest set bit: lowest line wins.
  assign int_sel  = int_elig & (~int_elig + ONE);

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    cause_d       = cause_q;
    epc_d         = epc_q;
    int_take_d    = int_take_q;
    in_handler_d  = in_handler_q;
    pend_d        = pend_q | int_edge;
    exception_o   = 1'b0;
    cause_o       = '0;
    epc_pc_o      = '0;
    eret_o        = 1'b0;
    stall_c       = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;

    unique case (state_q)
      S_IDLE: begin
        if (teq_en || brk_en || sys_en) begin
          state_d    = S_TAKE;
          epc_d      = pc_i;
          int_take_d = '0;
          stall_c    = 1'b1;
          cause_d    = teq_en ? EXC_TR : (brk_en ? EXC_BP : EXC_SYS);
        end else if (eret_en) begin
          state_d = S_RET;
        end else if (|int_sel) begin
          state_d    = S_TAKE;
          epc_d      = pc_i;
          int_take_d = int_sel;
          cause_d    = EXC_INT;
          stall_c    = 1'b1;
        end
      end
      S_TAKE: begin
        exception_o  = 1'b1;
        cause_o      = cause_q;
        epc_pc_o     = epc_q;
        stall_c      = 1'b1;
        in_handler_d = 1'b1;
        pend_d       = (pend_q & ~int_take_q) | int_edge;
        state_d      = S_VECTOR;
      end
      S_VECTOR: begin
        redirect_o    = 1'b1;
        redirect_pc_o = HANDLER_ADDR;
        stall_c       = 1'b1;
        state_d       = S_IDLE;
      end
      S_RET: begin
        eret_o        = 1'b1;
        redirect_o    = 1'b1;
        redirect_pc_o = exc_addr_i;
        stall_c       = 1'b1;
        in_handler_d  = 1'b0;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // IDLE stall is input-driven; gating with rst_n keeps it quiet while reset is held.
  assign stall_o       = stall_c & rst_n;
  assign int_pending_o = pend_q;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cause_q      <= '0;
      epc_q        <= '0;
      int_take_q   <= '0;
      pend_q       <= '0;
      in_handler_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      epc_q        <= epc_d;
      int_take_q   <= int_take_d;
      pend_q       <= pend_d;
      in_handler_q <= in_handler_d;
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: a per-cycle vector table for trap sequencing plus
// hand-written sequences for interrupts, ERET interaction and mid-sequence reset.
module tb_cp0_exc_ctrl;

  localparam logic [31:0] H = 32'h0040_0004;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] pc;
  logic        syscall, brk, teq_trap, eret_req;
  logic [5:0]  ext_int;
  logic [31:0] status, exc_addr;
  logic        exception, eret, stall, redirect;
  logic [4:0]  cause;
  logic [31:0] epc_pc, redirect_pc;
  logic [5:0]  int_pending;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cp0_exc_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid_i (instr_valid),
    .pc_i          (pc),
    .syscall_i     (syscall),
    .brk_i         (brk),
    .teq_trap_i    (teq_trap),
    .eret_req_i    (eret_req),
    .ext_int_i     (ext_int),
    .status_i      (status),
    .exc_addr_i    (exc_addr),
    .exception_o   (exception),
    .cause_o       (cause),
    .epc_pc_o      (epc_pc),
    .eret_o        (eret),
    .stall_o       (stall),
    .redirect_o    (redirect),
    .redirect_pc_o (redirect_pc),
    .int_pending_o (int_pending)
  );

  // trap = {teq, brk, syscall, eret_req}
  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [3:0]  trap;
    logic [31:0] st;
    logic [31:0] ea;
    logic        exc;
    logic [4:0]  cause;
    logic [31:0] epc;
    logic        eret;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic exc, input logic [4:0] cs,
                            input logic [31:0] epc, input logic er, input logic stl,
                            input logic rd, input logic [31:0] rpc, input logic [5:0] pend);
    check({tag, ".exception"},  32'(exception),   32'(exc));
    check({tag, ".cause"},      32'(cause),       32'(cs));
    check({tag, ".epc_pc"},     epc_pc,           epc);
    check({tag, ".eret"},       32'(eret),        32'(er));
    check({tag, ".stall"},      32'(stall),       32'(stl));
    check({tag, ".redirect"},   32'(redirect),    32'(rd));
    check({tag, ".redirect_pc"}, redirect_pc,     rpc);
    check({tag, ".int_pending"}, 32'(int_pending), 32'(pend));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] p, input logic [3:0] trap);
    instr_valid = iv;
    pc          = p;
    {teq_trap, brk, syscall, eret_req} = trap;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 4'b0000);
    ext_int = '0;
    #2;
    check_outs("reset", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 6'h00);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; status = 32'h0; exc_addr = 32'h0;
    drive(1'b0, 32'h0, 4'b0000);
    ext_int = '0;

    //                iv    pc            trap     status       exc_addr      exc   cause  epc           eret  stall redir rpc
    vecs.push_back('{1'b1, 32'h00400020, 4'b0010, 32'h0000000F, 32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0,        4'b0000, 32'h0000000F, 32'h0,        1'b1, 5'd8,  32'h00400020, 1'b0, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0,        4'b0000, 32'h0000000F, 32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, H});
    vecs.push_back('{1'b0, 32'h0,        4'b0000, 32'h0000000F, 32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h00400030, 4'b0010, 32'h0000000D, 32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0,        4'b0000, 32'h0000000D, 32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h00400034, 4'b0001, 32'h0000000F, 32'h00400024, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0,        4'b0000, 32'h0000000F, 32'h00400024, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b1, 32'h00400024});
    vecs.push_back('{1'b0, 32'h0,        4'b0000, 32'h0000000F, 32'h00400024, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h00000100, 4'b0110, 32'h0000000F, 32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0,        4'b0000, 32'h0000000F, 32'h0,        1'b1, 5'd9,  32'h00000100, 1'b0, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0,        4'b0000, 32'h0000000F, 32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, H});
    vecs.push_back('{1'b0, 32'h0,        4'b0000, 32'h0000000F, 32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h00000180, 4'b1000, 32'h0000000F, 32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h00000200, 4'b1111, 32'h0000000F, 32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h00000200, 4'b1111, 32'h0000000F, 32'h0,        1'b1, 5'd13, 32'h00000200, 1'b0, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0,        4'b0000, 32'h0000000F, 32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, H});
    vecs.push_back('{1'b0, 32'h0,        4'b0000, 32'h0000000F, 32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h00000280, 4'b0010, 32'h0000000E, 32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h00000300, 4'b1100, 32'h00000007, 32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0,        4'b0000, 32'h00000007, 32'h0,        1'b1, 5'd9,  32'h00000300, 1'b0, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0,        4'b0000, 32'h00000007, 32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b1, H});
    vecs.push_back('{1'b0, 32'h0,        4'b0000, 32'h00000007, 32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0});

    do_reset();
    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].pc, vecs[i].trap);
      status   = vecs[i].st;
      exc_addr = vecs[i].ea;
      #2;
      check_outs($sformatf("vec%0d", i), vecs[i].exc, vecs[i].cause, vecs[i].epc, vecs[i].eret,
                 vecs[i].stall, vecs[i].redir, vecs[i].rpc, 6'h00);
      tick();
    end

    // Masked interrupt pulse is remembered, then taken once its enable is set.
    do_reset();
    status = 32'h00000001;
    ext_int = 6'b000100;
    tick();
    ext_int = '0;
    repeat (4) tick();
    drive(1'b1, 32'h00400050, 4'b0000);
    #2;
    check_outs("int_masked", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000100);
    tick();
    status = 32'h00000401;
    #2;
    check_outs("int_req", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 6'b000100);
    tick();
    drive(1'b0, 32'h0, 4'b0000);
    #2;
    check_outs("int_take", 1'b1, 5'd0, 32'h00400050, 1'b0, 1'b1, 1'b0, 32'h0, 6'b000100);
    tick();
    #2;
    check_outs("int_vector", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1, H, 6'b000000);
    tick();

    // Leave the handler, then teq together with an ext_int[0] edge.
    drive(1'b1, H, 4'b0001);
    exc_addr = 32'h00400054;
    tick();
    drive(1'b0, 32'h0, 4'b0000);
    tick();
    status = 32'h0000010F;
    drive(1'b1, 32'h00400060, 4'b1000);
    ext_int = 6'b000001;
    #2;
    check_outs("teq_int_req", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 6'b000000);
    tick();
    drive(1'b0, 32'h0, 4'b0000);
    #2;
    check_outs("teq_int_take", 1'b1, 5'd13, 32'h00400060, 1'b0, 1'b1, 1'b0, 32'h0, 6'b000000);
    tick();
    tick();
    drive(1'b1, 32'h00400004, 4'b0000);
    repeat (2) tick();
    #2;
    check_outs("in_handler_hold", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000001);
    drive(1'b1, 32'h00400008, 4'b0001);
    exc_addr = 32'h00400060;
    tick();
    drive(1'b0, 32'h0, 4'b0000);
    #2;
    check_outs("eret_pulse", 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h00400060, 6'b000001);
    tick();
    drive(1'b1, 32'h00400060, 4'b0000);
    #2;
    check_outs("int0_req", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 6'b000001);
    tick();
    drive(1'b0, 32'h0, 4'b0000);
    #2;
    check_outs("int0_take", 1'b1, 5'd0, 32'h00400060, 1'b0, 1'b1, 1'b0, 32'h0, 6'b000001);
    tick();
    #2;
    check_outs("int0_vector", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1, H, 6'b000000);
    tick();
    ext_int = '0;

    // Asynchronous reset in VECTOR with decode still holding the syscall.
    do_reset();
    status = 32'h0000000F;
    drive(1'b1, 32'h00400070, 4'b0010);
    tick();
    tick();
    #2;
    check_outs("rst_vector", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1, H, 6'h00);
    rst_n = 1'b0;
    #1;
    check_outs("rst_async", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 6'h00);
    tick();
    drive(1'b0, 32'h0, 4'b0000);
    rst_n = 1'b1;
    tick();
    #2;
    check_outs("rst_release", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 6'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
